mem_arbiter: RTL and testbench

- Shares one slow-memory port (128-bit line, ready handshake) between the I-cache and D-cache miss/writeback interfaces.
- Sits inside CHIP between the two caches and a single external memory port, or an L2 cache port.
- Serves one line transaction at a time, with fixed D-side priority by default.
- Adds one request cycle and zero cycles on the response path.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I-cache / D-cache memory port arbiter.
package mem_arb_pkg;

    localparam int MEM_ARB_ADDR_W = 28;
    localparam int MEM_ARB_DATA_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_I   = 2'd1,
        ST_GNT_D   = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    // Grant-side encoding, also the encoding of the round-robin history bit.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    function automatic logic [1:0] grant_state(input logic side);
        return (side == GRANT_D) ? ST_GNT_D : ST_GNT_I;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: a lone requester wins, a tie goes to the side
// that was not granted last.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_side
);

    always_comb begin
        grant_valid = req_i | req_d;
        if (req_i && req_d) begin
            grant_side = ~last_grant;
        end else if (req_d) begin
            grant_side = GRANT_D;
        end else begin
            grant_side = GRANT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache, one transaction at a time.
// Build option MEM_ARB_RR_EN: round-robin on ties instead of fixed D-over-I priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ARB_ADDR_W,
    parameter int DATA_W = MEM_ARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] GNT_I   = ST_GNT_I;
    localparam logic [1:0] GNT_D   = ST_GNT_D;
    localparam logic [1:0] RELEASE = ST_RELEASE;

    logic [1:0] state;
    logic       grant_valid;
    logic       grant_side;
    logic       last_grant;

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_I;
        end else if (state == IDLE && grant_valid) begin
            last_grant <= grant_side;
        end
    end
`else
    // Pinning the history to I makes the picker resolve every tie to D.
    assign last_grant = GRANT_I;
`endif

    mem_arb_pick u_pick (
        .req_i       (i_read | i_write),
        .req_d       (d_read | d_write),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_side  (grant_side)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state <= grant_state(grant_side);
                        if (grant_side == GRANT_D) begin
                            mem_read  <= d_read;
                            mem_write <= d_write;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_read  <= i_read;
                            mem_write <= i_write;
                            mem_addr  <= i_addr;
                            mem_wdata <= i_wdata;
                        end
                    end
                end
                GNT_I, GNT_D: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= RELEASE;
                    end
                end
                // RELEASE absorbs the cycle in which the served cache still holds its request.
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign i_ready = mem_ready && (state == GNT_I);
    assign d_ready = mem_ready && (state == GNT_D);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cases plus random rounds scored against a
// transaction-level model of grant order, command contents and issue cycles.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int EXP_W  = 1 + 2 + ADDR_W + DATA_W;  // {side, write, read, addr, wdata}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              i_read, i_write, d_read, d_write;
    logic [ADDR_W-1:0] i_addr, d_addr, mem_addr;
    logic [DATA_W-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic              i_ready, d_ready, mem_read, mem_write, mem_ready, busy;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_read    (i_read),
        .i_write   (i_write),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [EXP_W-1:0]  exp_q[$];
    int                exp_cyc_q[$];
    int                lat_q[$];
    logic [DATA_W-1:0] rdat_q[$];
    logic              model_last;

    // request descriptors, index 0 = I side, 1 = D side
    logic              rq_en[2];
    logic [1:0]        rq_op[2];   // {write, read}
    logic [ADDR_W-1:0] rq_addr[2];
    logic [DATA_W-1:0] rq_wdata[2];
    logic [DATA_W-1:0] rq_rdat[2];
    int                rq_off[2], rq_lat[2], rq_hold[2];
    int                raise_at[2], drop_at[2];

    logic              mem_active;
    logic [EXP_W-1:0]  cur_exp;
    logic [DATA_W-1:0] cur_rdat;
    int                ready_at;
    int                n_issued;
    int                done_cnt;

    task automatic chk(input string tag, input logic [EXP_W-1:0] obs, input logic [EXP_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_side(input int s, input logic rd, input logic wr,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w);
        if (s == 0) begin
            i_read = rd; i_write = wr; i_addr = a; i_wdata = w;
        end else begin
            d_read = rd; d_write = wr; d_addr = a; d_wdata = w;
        end
    endtask

    task automatic set_req(input int s, input logic en, input logic [1:0] op,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w,
                           input int off, input int lat, input logic [DATA_W-1:0] rd, input int hold);
        rq_en[s] = en; rq_op[s] = op; rq_addr[s] = a; rq_wdata[s] = w;
        rq_off[s] = off; rq_lat[s] = lat; rq_rdat[s] = rd; rq_hold[s] = hold;
    endtask

    // One clock: drive at posedge+1, observe at negedge.
    task automatic tick();
        logic             side;
        logic [EXP_W-1:0] obs;
        @(posedge clk);
        cyc++;
        #1;
        mem_ready = 1'b0;
        mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int s = 0; s < 2; s++) begin
            if (raise_at[s] == cyc) drive_side(s, rq_op[s][0], rq_op[s][1], rq_addr[s], rq_wdata[s]);
            if (drop_at[s] == cyc)  drive_side(s, 1'b0, 1'b0, rq_addr[s], rq_wdata[s]);
        end
        if (mem_active && ready_at == cyc) begin
            mem_ready = 1'b1;
            mem_rdata = cur_rdat;
        end
        @(negedge clk);
        if (mem_active) begin
            side = cur_exp[EXP_W-1];
            obs  = {side, mem_write, mem_read, mem_addr, mem_wdata};
            chk("cmd_hold", obs, cur_exp);
            chk("busy_gnt", busy, 1);
            if (mem_ready) begin
                if (side) begin
                    chk("d_ready", d_ready, 1);
                    chk("i_ready_quiet", i_ready, 0);
                    chk("d_rdata", d_rdata, cur_rdat);
                end else begin
                    chk("i_ready", i_ready, 1);
                    chk("d_ready_quiet", d_ready, 0);
                    chk("i_rdata", i_rdata, cur_rdat);
                end
                mem_active    = 1'b0;
                drop_at[side] = cyc + 1 + rq_hold[side];
                done_cnt++;
            end else begin
                chk("ready_idle", {i_ready, d_ready}, 0);
            end
        end else if (mem_read || mem_write) begin
            n_issued++;
            if (exp_q.size() == 0) begin
                chk("unexpected_cmd", {mem_write, mem_read}, 0);
            end else begin
                cur_exp  = exp_q.pop_front();
                cur_rdat = rdat_q.pop_front();
                obs      = {cur_exp[EXP_W-1], mem_write, mem_read, mem_addr, mem_wdata};
                chk("cmd", obs, cur_exp);
                chk("issue_cyc", cyc, exp_cyc_q.pop_front());
                ready_at   = cyc + lat_q.pop_front();
                mem_active = 1'b1;
            end
        end
    endtask

    // Model: work out grant order and issue cycles, then run the round.
    task automatic run_round();
        int base, first, issue, n, start_issued;
        int order[$];
        base = cyc + 1;
        if (rq_en[0] && rq_en[1]) begin
            if (rq_off[0] == rq_off[1]) begin
`ifdef MEM_ARB_RR_EN
                first = (model_last == GRANT_D) ? 0 : 1;
`else
                first = 1;
`endif
            end else begin
                first = (rq_off[0] < rq_off[1]) ? 0 : 1;
            end
            order.push_back(first);
            order.push_back(1 - first);
        end else begin
            order.push_back(rq_en[1] ? 1 : 0);
        end
        // first command one cycle after its request; each later one 3 cycles after the previous ready
        issue = base + rq_off[order[0]] + 1;
        foreach (order[k]) begin
            exp_q.push_back({order[k][0], rq_op[order[k]], rq_addr[order[k]], rq_wdata[order[k]]});
            exp_cyc_q.push_back(issue);
            lat_q.push_back(rq_lat[order[k]]);
            rdat_q.push_back(rq_rdat[order[k]]);
            issue      = issue + rq_lat[order[k]] + 3;
            model_last = order[k][0];
        end
        for (int s = 0; s < 2; s++) begin
            raise_at[s] = rq_en[s] ? base + rq_off[s] : -1;
            drop_at[s]  = -1;
        end
        n            = order.size();
        done_cnt     = 0;
        start_issued = n_issued;
        for (int t = 0; t < 300 && done_cnt < n; t++) tick();
        chk("round_done", done_cnt, n);
        repeat (4) tick();
        chk("round_txns", n_issued - start_issued, n);
        chk("idle_busy", busy, 0);
        exp_q.delete(); exp_cyc_q.delete(); lat_q.delete(); rdat_q.delete();
        mem_active = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [1:0] op;
        int         v;
        rst_n = 1'b0;
        drive_side(0, 1'b0, 1'b0, '0, '0);
        drive_side(1, 1'b0, 1'b0, '0, '0);
        mem_ready = 1'b0; mem_rdata = '0;
        mem_active = 1'b0; n_issued = 0; done_cnt = 0; ready_at = 0;
        cur_exp = '0; cur_rdat = '0; model_last = GRANT_I;
        for (int s = 0; s < 2; s++) begin
            raise_at[s] = -1; drop_at[s] = -1;
            set_req(s, 1'b0, 2'b01, '0, '0, 0, 3, '0, 0);
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd", {mem_read, mem_write, i_ready, d_ready, busy}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // lone I read, ready 10 cycles after the command
        set_req(0, 1'b1, 2'b01, 28'h0000010, '0, 0, 10, {16{8'hA5}}, 0);
        set_req(1, 1'b0, 2'b01, '0, '0, 0, 3, '0, 0);
        run_round();

        // simultaneous D write / I read, twice
        for (int r = 0; r < 2; r++) begin
            set_req(0, 1'b1, 2'b01, 28'h0000030, '0, 0, 4, {4{32'hC0DE_0000 + r}}, 0);
            set_req(1, 1'b1, 2'b10, 28'h0000020, {8{16'h1234}}, 0, 5, '0, 0);
            run_round();
        end

        // requester holds one cycle past ready: still exactly one transaction
        set_req(0, 1'b1, 2'b01, 28'h0000044, '0, 0, 3, {4{32'h0BAD_F00D}}, 1);
        set_req(1, 1'b0, 2'b01, '0, '0, 0, 3, '0, 0);
        run_round();

        // spurious mem_ready while idle
        @(posedge clk); #1 mem_ready = 1'b1;
        #1;
        chk("spur_ready", {i_ready, d_ready}, 0);
        @(posedge clk); #1 mem_ready = 1'b0;
        chk("spur_state", {busy, mem_read, mem_write}, 0);

        // async reset four cycles into a D read
        @(posedge clk); #1 drive_side(1, 1'b1, 1'b0, 28'h0000050, '0);
        repeat (4) @(posedge clk);
        #1 mem_ready = 1'b1; mem_rdata = {4{32'h5555_AAAA}};
        #1 chk("pre_rst", {mem_read, d_ready, busy}, 3'b111);
        #1 rst_n = 1'b0;
        #1 chk("async_rst", {mem_read, d_ready, busy}, 0);
        chk("async_rst_addr", mem_addr, 0);
        mem_ready = 1'b0;
        drive_side(1, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        model_last = GRANT_I;

        // I read after reset is served normally
        set_req(0, 1'b1, 2'b01, 28'h0000060, '0, 0, 6, {4{32'h1357_9BDF}}, 0);
        set_req(1, 1'b0, 2'b01, '0, '0, 0, 3, '0, 0);
        run_round();

        // random rounds
        for (int r = 0; r < 30; r++) begin
            for (int s = 0; s < 2; s++) begin
                v  = $urandom_range(0, 7);
                op = (v < 4) ? 2'b01 : (v < 7) ? 2'b10 : 2'b11;
                set_req(s, 1'($urandom_range(0, 1)), op, ADDR_W'($urandom()),
                        {$urandom(), $urandom(), $urandom(), $urandom()},
                        $urandom_range(0, 2), $urandom_range(3, 8),
                        {$urandom(), $urandom(), $urandom(), $urandom()},
                        $urandom_range(0, 1));
            end
            if (!rq_en[0] && !rq_en[1]) rq_en[$urandom_range(0, 1)] = 1'b1;
            run_round();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
